ysyx_040066_mem_arbiter: RTL and testbench

YSYX_040066_MEM_ARBITER -- requirements
Module: ysyx_040066_mem_arbiter

---
 rtl/ysyx_040066_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ysyx_040066_mem_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040066_mem_arbiter.sv
// Three-way arbiter sharing one memory read port and one write port between icache reads,
// dcache reads and dcache writes. Define YSYX_040066_ARB_RR_EN for round-robin read arbitration.
module ysyx_040066_mem_arbiter #(
  parameter int unsigned AW = 64,
  parameter int unsigned LW = 3
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          ins_req,
  input  logic          ins_burst,
  input  logic [AW-1:0] ins_addr,
  output logic          ins_ready,
  output logic          ins_last,
  output logic          ins_err,
  output logic [63:0]   ins_data,

  input  logic          d_rd_req,
  input  logic          d_rd_burst,
  input  logic [LW-1:0] d_rd_len,
  input  logic [AW-1:0] d_rd_addr,
  output logic          d_rd_ready,
  output logic          d_rd_last,
  output logic          d_rd_err,
  output logic [63:0]   d_rd_data,

  input  logic          d_wr_req,
  input  logic          d_wr_burst,
  input  logic [LW-1:0] d_wr_len,
  input  logic [7:0]    d_wr_mask,
  input  logic [AW-1:0] d_wr_addr,
  input  logic [511:0]  d_wr_data,
  output logic          d_wr_ready,
  output logic          d_wr_err,

  output logic          m_rd_req,
  output logic          m_rd_burst,
  output logic [LW-1:0] m_rd_len,
  output logic [AW-1:0] m_rd_addr,
  input  logic          m_rd_ready,
  input  logic          m_rd_last,
  input  logic          m_rd_err,
  input  logic [63:0]   m_rd_data,

  output logic          m_wr_req,
  output logic          m_wr_burst,
  output logic [LW-1:0] m_wr_len,
  output logic [7:0]    m_wr_mask,
  output logic [AW-1:0] m_wr_addr,
  output logic [511:0]  m_wr_data,
  input  logic          m_wr_ready,
  input  logic          m_wr_err,

  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIrd  = 2'd1,
    StDrd  = 2'd2,
    StDwr  = 2'd3
  } state_e;

  // icache bursts are always a full 8-beat line.
  localparam logic [LW-1:0] IrdBurstLen = LW'(7);

  state_e state_q, state_d;
  logic   rd_done;
  logic   wr_done;
  logic   pick_drd;

  assign rd_done = m_rd_err | (m_rd_ready & m_rd_last);
  assign wr_done = m_wr_err | m_wr_ready;

`ifdef YSYX_040066_ARB_RR_EN
  // Set when the dcache read was the most recent read to complete.
  logic rr_dc_last_q, rr_dc_last_d;

  assign pick_drd = d_rd_req & (~ins_req | ~rr_dc_last_q);

  always_comb begin
    rr_dc_last_d = rr_dc_last_q;
    if (rd_done && state_q == StIrd) rr_dc_last_d = 1'b0;
    if (rd_done && state_q == StDrd) rr_dc_last_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_dc_last_q <= 1'b0;
    end else begin
      rr_dc_last_q <= rr_dc_last_d;
    end
  end
`else
  assign pick_drd = d_rd_req;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (d_wr_req)     state_d = StDwr;
        else if (pick_drd) state_d = StDrd;
        else if (ins_req)  state_d = StIrd;
      end
      StIrd, StDrd: begin
        if (rd_done) state_d = StIdle;
      end
      StDwr: begin
        if (wr_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign grant     = state_q;
  assign ins_data  = m_rd_data;
  assign d_rd_data = m_rd_data;

  // Request fields and responses are steered purely by the registered owner, so a requester
  // that drops its request mid-transaction still sees its remaining responses.
  always_comb begin
    m_rd_req   = 1'b0;
    m_rd_burst = 1'b0;
    m_rd_len   = '0;
    m_rd_addr  = '0;
    m_wr_req   = 1'b0;
    m_wr_burst = 1'b0;
    m_wr_len   = '0;
    m_wr_mask  = '0;
    m_wr_addr  = '0;
    m_wr_data  = '0;
    ins_ready  = 1'b0;
    ins_last   = 1'b0;
    ins_err    = 1'b0;
    d_rd_ready = 1'b0;
    d_rd_last  = 1'b0;
    d_rd_err   = 1'b0;
    d_wr_ready = 1'b0;
    d_wr_err   = 1'b0;
    case (state_q)
      StIrd: begin
        m_rd_req   = 1'b1;
        m_rd_addr  = ins_addr;
        m_rd_burst = ins_burst;
        m_rd_len   = ins_burst ? IrdBurstLen : '0;
        ins_ready  = m_rd_ready;
        ins_last   = m_rd_last;
        ins_err    = m_rd_err;
      end
      StDrd: begin
        m_rd_req   = 1'b1;
        m_rd_addr  = d_rd_addr;
        m_rd_burst = d_rd_burst;
        m_rd_len   = d_rd_len;
        d_rd_ready = m_rd_ready;
        d_rd_last  = m_rd_last;
        d_rd_err   = m_rd_err;
      end
      StDwr: begin
        m_wr_req   = 1'b1;
        m_wr_addr  = d_wr_addr;
        m_wr_burst = d_wr_burst;
        m_wr_len   = d_wr_len;
        m_wr_mask  = d_wr_mask;
        m_wr_data  = d_wr_data;
        d_wr_ready = m_wr_ready;
        d_wr_err   = m_wr_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Scoreboard bench for ysyx_040066_mem_arbiter: a memory responder model drives the shared
// ports, stimulus pushes expected grants/responses, and a monitor pops and compares them.
module tb_ysyx_040066_mem_arbiter;

  localparam int AW = 64;
  localparam int LW = 3;

  logic          clk, rst;
  logic          ins_req, ins_burst, ins_ready, ins_last, ins_err;
  logic [AW-1:0] ins_addr;
  logic [63:0]   ins_data;
  logic          d_rd_req, d_rd_burst, d_rd_ready, d_rd_last, d_rd_err;
  logic [LW-1:0] d_rd_len;
  logic [AW-1:0] d_rd_addr;
  logic [63:0]   d_rd_data;
  logic          d_wr_req, d_wr_burst, d_wr_ready, d_wr_err;
  logic [LW-1:0] d_wr_len;
  logic [7:0]    d_wr_mask;
  logic [AW-1:0] d_wr_addr;
  logic [511:0]  d_wr_data;
  logic          m_rd_req, m_rd_burst, m_rd_ready, m_rd_last, m_rd_err;
  logic [LW-1:0] m_rd_len;
  logic [AW-1:0] m_rd_addr;
  logic [63:0]   m_rd_data;
  logic          m_wr_req, m_wr_burst, m_wr_ready, m_wr_err;
  logic [LW-1:0] m_wr_len;
  logic [7:0]    m_wr_mask;
  logic [AW-1:0] m_wr_addr;
  logic [511:0]  m_wr_data;
  logic [1:0]    grant;

  ysyx_040066_mem_arbiter #(.AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .ins_req(ins_req), .ins_burst(ins_burst), .ins_addr(ins_addr),
    .ins_ready(ins_ready), .ins_last(ins_last), .ins_err(ins_err), .ins_data(ins_data),
    .d_rd_req(d_rd_req), .d_rd_burst(d_rd_burst), .d_rd_len(d_rd_len), .d_rd_addr(d_rd_addr),
    .d_rd_ready(d_rd_ready), .d_rd_last(d_rd_last), .d_rd_err(d_rd_err), .d_rd_data(d_rd_data),
    .d_wr_req(d_wr_req), .d_wr_burst(d_wr_burst), .d_wr_len(d_wr_len), .d_wr_mask(d_wr_mask),
    .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ready(d_wr_ready), .d_wr_err(d_wr_err),
    .m_rd_req(m_rd_req), .m_rd_burst(m_rd_burst), .m_rd_len(m_rd_len), .m_rd_addr(m_rd_addr),
    .m_rd_ready(m_rd_ready), .m_rd_last(m_rd_last), .m_rd_err(m_rd_err), .m_rd_data(m_rd_data),
    .m_wr_req(m_wr_req), .m_wr_burst(m_wr_burst), .m_wr_len(m_wr_len), .m_wr_mask(m_wr_mask),
    .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_ready(m_wr_ready), .m_wr_err(m_wr_err),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  flags;  // {ins_ready,ins_last,ins_err,d_rd_ready,d_rd_last,d_rd_err,d_wr_ready,d_wr_err}
    logic [63:0] data;
    logic [63:0] addr;
    logic [2:0]  len;
    logic        burst;
    logic [7:0]  mask;
  } rsp_t;

  typedef struct {
    logic [1:0] g;
    int         idle;  // expected idle cycles before this grant, -1 = don't care
  } gnt_t;

  rsp_t rsp_q[$];
  gnt_t gnt_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   rd_err_beat = 0;
  bit   wr_err_cfg = 1'b0;

  function automatic logic [63:0] pat(input logic [63:0] addr, input int beat);
    return {addr[31:0] + 32'(beat * 8), 32'hA5A5_0000 | 32'(beat)};
  endfunction

  task automatic check(input bit ok, input string name, input string detail);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic push_gnt(input logic [1:0] g, input int idle);
    gnt_t e;
    e.g = g;
    e.idle = idle;
    gnt_q.push_back(e);
  endtask

  task automatic push_rd(input bit dc, input logic [63:0] addr, input logic burst,
                         input logic [2:0] len, input int err_beat, input int max_beats);
    int full_n;
    int n;
    full_n = burst ? int'(len) + 1 : 1;
    n = (max_beats < full_n) ? max_beats : full_n;
    for (int i = 0; i < n; i++) begin
      rsp_t r;
      logic last;
      r.data = pat(addr, i);
      r.addr = addr;
      r.len = len;
      r.burst = burst;
      r.mask = 8'h00;
      if (err_beat == i + 1) begin
        r.flags = dc ? 8'b0000_0100 : 8'b0010_0000;
        rsp_q.push_back(r);
        break;
      end
      last = (i == full_n - 1);
      r.flags = dc ? {3'b000, 1'b1, last, 3'b000} : {1'b1, last, 6'b000000};
      rsp_q.push_back(r);
    end
  endtask

  task automatic push_wr(input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data,
                         input bit err);
    rsp_t r;
    r.flags = err ? 8'h01 : 8'h02;
    r.data = data;
    r.addr = addr;
    r.len = 3'd0;
    r.burst = 1'b0;
    r.mask = mask;
    rsp_q.push_back(r);
  endtask

  // kind: 0 icache read, 1 dcache read, 2 dcache write; drop_at releases d_rd_req early.
  task automatic wait_done(input int kind, input int drop_at);
    int beats;
    bit done;
    beats = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      case (kind)
        0: done = (ins_ready && ins_last) || ins_err;
        1: begin
          if (d_rd_ready) beats++;
          done = (d_rd_ready && d_rd_last) || d_rd_err;
          if (drop_at > 0 && beats == drop_at) d_rd_req = 1'b0;
        end
        default: done = d_wr_ready || d_wr_err;
      endcase
    end
    check(done, "completion", $sformatf("requester %0d done=%0b, required 1", kind, done));
    @(posedge clk);
    #1;
  endtask

  task automatic do_ird(input logic [63:0] addr, input logic burst);
    ins_addr = addr;
    ins_burst = burst;
    ins_req = 1'b1;
    wait_done(0, 0);
    ins_req = 1'b0;
  endtask

  task automatic do_drd(input logic [63:0] addr, input logic burst, input logic [2:0] len,
                        input int drop_at);
    d_rd_addr = addr;
    d_rd_burst = burst;
    d_rd_len = len;
    d_rd_req = 1'b1;
    wait_done(1, drop_at);
    d_rd_req = 1'b0;
  endtask

  task automatic do_dwr(input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
    d_wr_addr = addr;
    d_wr_mask = mask;
    d_wr_data = {8{data}};
    d_wr_burst = 1'b0;
    d_wr_len = '0;
    d_wr_req = 1'b1;
    wait_done(2, 0);
    d_wr_req = 1'b0;
  endtask

  // Memory responder: reads return one beat per cycle, writes answer after one wait cycle.
  initial begin
    int rd_beat;
    int n;
    bit wr_wait;
    rd_beat = 0;
    wr_wait = 1'b0;
    m_rd_ready = 1'b0; m_rd_last = 1'b0; m_rd_err = 1'b0; m_rd_data = '0;
    m_wr_ready = 1'b0; m_wr_err = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_rd_ready = 1'b0; m_rd_last = 1'b0; m_rd_err = 1'b0; m_rd_data = '0;
      m_wr_ready = 1'b0; m_wr_err = 1'b0;
      if (m_rd_req) begin
        n = m_rd_burst ? int'(m_rd_len) + 1 : 1;
        m_rd_data = pat(m_rd_addr, rd_beat);
        if (rd_err_beat == rd_beat + 1) begin
          m_rd_err = 1'b1;
          rd_beat = 0;
        end else begin
          m_rd_ready = 1'b1;
          m_rd_last = (rd_beat == n - 1);
          rd_beat = (rd_beat == n - 1) ? 0 : rd_beat + 1;
        end
      end else begin
        rd_beat = 0;
      end
      if (m_wr_req) begin
        if (!wr_wait) begin
          wr_wait = 1'b1;
        end else begin
          wr_wait = 1'b0;
          if (wr_err_cfg) m_wr_err = 1'b1;
          else m_wr_ready = 1'b1;
        end
      end else begin
        wr_wait = 1'b0;
      end
    end
  end

  // Monitor: port exclusivity every cycle, grant order on each new grant, responses on each event.
  initial begin
    logic [1:0] prev_g;
    int zcnt;
    gnt_t e;
    rsp_t a, x;
    bit is_wr, ok;
    prev_g = 2'd0;
    zcnt = 0;
    forever begin
      @(negedge clk);
      check(!(m_rd_req && m_wr_req) && !(grant == 2'd0 && (m_rd_req || m_wr_req)), "req_excl",
            $sformatf("grant=%0d m_rd_req=%0b m_wr_req=%0b, required exclusive and idle-low",
                      grant, m_rd_req, m_wr_req));
      if (grant == 2'd0) begin
        zcnt++;
      end else begin
        if (grant != prev_g) begin
          if (gnt_q.size() == 0) begin
            check(1'b0, "grant_unexpected", $sformatf("grant=%0d, required none pending", grant));
          end else begin
            e = gnt_q.pop_front();
            check(grant == e.g && (e.idle < 0 || zcnt == e.idle), "grant_order",
                  $sformatf("grant=%0d after %0d idle, required %0d after %0d idle",
                            grant, zcnt, e.g, e.idle));
          end
        end
        zcnt = 0;
      end
      prev_g = grant;

      a.flags = {ins_ready, ins_last, ins_err, d_rd_ready, d_rd_last, d_rd_err,
                 d_wr_ready, d_wr_err};
      if (a.flags != 8'h00) begin
        is_wr = d_wr_ready || d_wr_err;
        a.data  = is_wr ? m_wr_data[63:0] : ((ins_ready || ins_err) ? ins_data : d_rd_data);
        a.addr  = is_wr ? m_wr_addr : m_rd_addr;
        a.len   = is_wr ? m_wr_len : m_rd_len;
        a.burst = is_wr ? m_wr_burst : m_rd_burst;
        a.mask  = is_wr ? m_wr_mask : 8'h00;
        if (rsp_q.size() == 0) begin
          check(1'b0, "rsp_unexpected", $sformatf("flags=%b, required no response", a.flags));
        end else begin
          x = rsp_q.pop_front();
          ok = (a.flags == x.flags) && (a.data == x.data) && (a.addr == x.addr) &&
               (a.len == x.len) && (a.burst == x.burst) && (a.mask == x.mask) &&
               (ins_data == m_rd_data) && (d_rd_data == m_rd_data);
          check(ok, "response",
                $sformatf("flags=%b data=%h addr=%h len=%0d burst=%0b mask=%h, required flags=%b data=%h addr=%h len=%0d burst=%0b mask=%h",
                          a.flags, a.data, a.addr, a.len, a.burst, a.mask,
                          x.flags, x.data, x.addr, x.len, x.burst, x.mask));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit rr;
`ifdef YSYX_040066_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst = 1'b0;
    ins_req = 0; ins_burst = 0; ins_addr = '0;
    d_rd_req = 0; d_rd_burst = 0; d_rd_len = '0; d_rd_addr = '0;
    d_wr_req = 0; d_wr_burst = 0; d_wr_len = '0; d_wr_mask = '0; d_wr_addr = '0; d_wr_data = '0;
    repeat (3) @(negedge clk);
    check(grant == 2'd0 && !m_rd_req && !m_wr_req && !ins_ready && !d_rd_ready && !d_wr_ready,
          "reset_state", $sformatf("grant=%0d m_rd_req=%0b m_wr_req=%0b, required all 0",
                                   grant, m_rd_req, m_wr_req));
    rst = 1'b1;

    // All three requesters rise together: write, then dcache read, then icache read.
    @(posedge clk); #1;
    push_gnt(2'd3, -1); push_gnt(2'd2, 1); push_gnt(2'd1, 1);
    push_wr(64'h1000, 8'hF0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    push_rd(1'b1, 64'h2000, 1'b1, 3'd3, 0, 99);
    push_rd(1'b0, 64'h3000, 1'b0, 3'd0, 0, 99);
    fork
      do_dwr(64'h1000, 8'hF0, 64'hDEAD_BEEF_0123_4567);
      do_drd(64'h2000, 1'b1, 3'd3, 0);
      do_ird(64'h3000, 1'b0);
    join

    // Lone icache burst: one-cycle grant latency, 8 beats, then idle.
    push_gnt(2'd1, -1);
    push_rd(1'b0, 64'h8000_0040, 1'b1, 3'd7, 0, 99);
    fork
      do_ird(64'h8000_0040, 1'b1);
      begin
        @(negedge clk);
        check(grant == 2'd0 && !m_rd_req, "ird_latency0",
              $sformatf("grant=%0d m_rd_req=%0b, required 0 0", grant, m_rd_req));
        @(negedge clk);
        check(grant == 2'd1 && m_rd_req && m_rd_len == 3'd7, "ird_latency1",
              $sformatf("grant=%0d m_rd_req=%0b len=%0d, required 1 1 7",
                        grant, m_rd_req, m_rd_len));
      end
    join
    @(negedge clk);
    check(grant == 2'd0, "ird_release", $sformatf("grant=%0d, required 0", grant));

    // dcache burst with an error on beat 3.
    rd_err_beat = 3;
    push_gnt(2'd2, -1);
    push_rd(1'b1, 64'h4000, 1'b1, 3'd7, 3, 99);
    do_drd(64'h4000, 1'b1, 3'd7, 0);
    rd_err_beat = 0;
    @(negedge clk);
    check(grant == 2'd0 && !d_rd_err && !ins_err, "drd_err_release",
          $sformatf("grant=%0d d_rd_err=%0b ins_err=%0b, required 0 0 0",
                    grant, d_rd_err, ins_err));

    // Write that fails.
    wr_err_cfg = 1'b1;
    push_gnt(2'd3, -1);
    push_wr(64'h7000, 8'h0F, 64'h1111_2222_3333_4444, 1'b1);
    do_dwr(64'h7000, 8'h0F, 64'h1111_2222_3333_4444);
    wr_err_cfg = 1'b0;

    // dcache owner drops its request after beat 2; the burst still completes to it.
    push_gnt(2'd2, -1);
    push_rd(1'b1, 64'h9000, 1'b1, 3'd7, 0, 99);
    do_drd(64'h9000, 1'b1, 3'd7, 2);

    // Both reads held continuously; the last read completed was a dcache read.
    ins_addr = 64'h5000; ins_burst = 1'b0;
    d_rd_addr = 64'h6000; d_rd_burst = 1'b0; d_rd_len = '0;
    for (int k = 0; k < 4; k++) begin
      bit dc;
      dc = rr ? (k % 2 == 1) : 1'b1;
      push_gnt(dc ? 2'd2 : 2'd1, (k == 0) ? -1 : 1);
      push_rd(dc, dc ? 64'h6000 : 64'h5000, 1'b0, 3'd0, 0, 99);
    end
    @(posedge clk); #1;
    ins_req = 1'b1; d_rd_req = 1'b1;
    cnt = 0;
    for (int c = 0; c < 400 && cnt < 4; c++) begin
      @(negedge clk);
      if ((ins_ready && ins_last) || (d_rd_ready && d_rd_last)) cnt++;
    end
    check(cnt == 4, "held_reads", $sformatf("%0d completions, required 4", cnt));
    @(posedge clk); #1;
    ins_req = 1'b0; d_rd_req = 1'b0;

    // Reset during beat 4 of an icache burst; the held request is re-granted after release.
    push_gnt(2'd1, -1);
    push_rd(1'b0, 64'h8000_0100, 1'b1, 3'd7, 0, 4);
    @(posedge clk); #1;
    ins_addr = 64'h8000_0100; ins_burst = 1'b1; ins_req = 1'b1;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 4; c++) begin
      @(negedge clk);
      if (ins_ready) cnt++;
    end
    check(cnt == 4, "beats_before_reset", $sformatf("%0d beats, required 4", cnt));
    #2;
    rst = 1'b0;
    #1;
    check(!m_rd_req && grant == 2'd0 && !ins_ready && !ins_last && !ins_err, "reset_mid_burst",
          $sformatf("m_rd_req=%0b grant=%0d ins_ready=%0b, required 0 0 0",
                    m_rd_req, grant, ins_ready));
    push_gnt(2'd1, -1);
    push_rd(1'b0, 64'h8000_0100, 1'b1, 3'd7, 0, 99);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check(grant == 2'd1 && m_rd_req, "regrant_after_reset",
          $sformatf("grant=%0d m_rd_req=%0b, required 1 1", grant, m_rd_req));
    wait_done(0, 0);
    ins_req = 1'b0;

    repeat (5) @(negedge clk);
    check(rsp_q.size() == 0, "rsp_drained",
          $sformatf("%0d responses outstanding, required 0", rsp_q.size()));
    check(gnt_q.size() == 0, "grant_drained",
          $sformatf("%0d grants outstanding, required 0", gnt_q.size()));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
